fb_mem_responder: RTL and testbench
===================================

Name: fb_mem_responder

Overview:
- Memory-side consumer of the framebuffer command/response FIFOs; the far end of the writer/reader FIFO protocol used by the framebuffer.
- Pops 41-bit commands and 32-bit burst-write data, then executes them as 16-bit word accesses on a simple request/ready memory port.
- Pushes single-read results (16b) and burst-read results (128b) into the reader FIFOs.
- Sits between the command/response FIFOs and the SDRAM controller front end.

Parameters:
ADDR_WIDTH, 24, word-address width driven on mem_addr_o; command address bits above it are dropped.
BURST_WORDS, 8, words per burst; fixed at 8 because the burst data path is 4x32b in and 128b out.

Ports:
clk  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
cmd_q_i  in  41  writer FIFO head (show-ahead)
cmd_empty_i  in  1  writer FIFO empty
cmd_deq_o  out  1  pop writer FIFO
burst_q_i  in  32  burst-write FIFO head (show-ahead)
burst_empty_i  in  1  burst-write FIFO empty
burst_deq_o  out  1  pop burst-write FIFO
rd_d_o  out  16  single-read result
rd_enq_o  out  1  push reader FIFO
rd_full_i  in  1  reader FIFO full
rd_burst_d_o  out  128  burst-read result
rd_burst_enq_o  out  1  push burst reader FIFO
rd_burst_full_i  in  1  burst reader FIFO full
mem_req_o  out  1  memory request
mem_we_o  out  1  1 = write
mem_addr_o  out  ADDR_WIDTH  word address
mem_wdata_o  out  16  write data
mem_ready_i  in  1  request accepted while mem_req_o is high
mem_rvalid_i  in  1  read data valid, one pulse per accepted read
mem_rdata_i  in  16  read data
busy_o  out  1  command in progress
err_o  out  1  one-cycle pulse on an illegal opcode

Behaviour:
- Command format:
  - [40] = we.
  - [39:16] = addr[23:0].
  - [15:0] = data when we = 1.
  - When we = 0, [1:0] is the opcode: 00 single read, 01 burst read, 10 burst write, 11 illegal.
- Reset: the FSM returns to IDLE and all outputs are 0, including the data registers. Reset asserted mid-operation aborts the operation with no FIFO push.
- Each memory request holds mem_req_o with stable addr/we/wdata until the cycle where mem_ready_i = 1.
- Only one read is outstanding at a time. A mem_rvalid_i pulse outside RD_WAIT is ignored.
- IDLE:
  - When !cmd_empty_i, assert cmd_deq_o for exactly 1 cycle, latch the command and go to DISPATCH.
  - busy_o = 1 in every state except IDLE.
- DISPATCH:
  - we = 1 -> SWR.
  - Opcode 00 -> SRD.
  - Opcode 01 -> BRD, base = addr & ~7, index = 0.
  - Opcode 10 -> BWR_FETCH, base = addr & ~7, index = 0.
  - Opcode 11 -> pulse err_o, return to IDLE, no memory access.
- SWR: write data to addr; on accept -> IDLE.
- SRD: request addr; on accept -> RD_WAIT; on rvalid -> RESP.
- RESP:
  - rd_d_o = rdata, held until !rd_full_i.
  - rd_enq_o is high for exactly 1 cycle, then IDLE.
- BRD:
  - Read base+i for i = 0..7, one outstanding at a time.
  - Word i lands in rd_burst_d_o[16i+15:16i].
  - After word 7 -> BRESP: wait for !rd_burst_full_i, pulse rd_burst_enq_o 1 cycle, then IDLE.
- BWR_FETCH:
  - On even i, wait for !burst_empty_i, latch burst_q_i and pulse burst_deq_o 1 cycle.
  - Word i = latched[15:0] for even i, latched[31:16] for odd i.
  - Exactly 4 pops per burst.
- BWR: write word i to base+i. On accept, i += 1; i = 8 -> IDLE, otherwise -> BWR_FETCH.
- Address arithmetic: base + i is computed in ADDR_WIDTH bits and never crosses the 8-aligned block. mem_addr_o = addr[ADDR_WIDTH-1:0].
- Commands are executed strictly in order; the next command is not popped until the current one returns to IDLE.
- A full reader FIFO stalls the FSM; the next command is never popped early.
- Minimum latency with mem_ready_i tied 1 and rvalid the next cycle: single write is 3 cycles from pop to next pop; single read pushes 4 cycles after pop.

Test Plan:
- Single write: cmd {we=1, addr 0x800010, data 0xABCD} -> exactly one mem write, addr 0x800010, wdata 0xABCD; cmd_deq_o pulses once; no reader push.
- Single read with stall: read 0x000123; memory returns 0x5A5A; rd_full_i=1 for 10 cycles -> rd_d_o=0x5A5A held, rd_enq_o pulses once only after full drops.
- Burst read: opcode 01, addr 0x800013 -> reads 0x800010..0x800017 in order; memory returns 0x1000+i -> rd_burst_d_o = 0x1007_1006_..._1000, one push.
- Burst write: burst FIFO holds 0x00020001, 0x00040003, 0x00060005, 0x00080007, empty for 5 cycles before the 3rd word -> writes 0x0001..0x0008 to base..base+7; 4 pops; the FSM stalls during the empty gap.
- Illegal opcode 11, then a single write -> err_o pulses 1 cycle, no memory access for the illegal command, then the write executes normally.
- Reset mid-burst-read after 3 words -> all outputs 0 and FSM in IDLE; after release, no burst push occurs, and the next command executes normally.

Source files
------------

// File: rtl/fb_mem_responder_if.sv
// rtl/fb_mem_responder_if.sv - FIFO and memory-port bundle for the framebuffer memory responder
interface fb_mem_responder_if #(
    parameter int ADDR_WIDTH = 24
);
    logic [40:0]           cmd_q_i;
    logic                  cmd_empty_i;
    logic                  cmd_deq_o;
    logic [31:0]           burst_q_i;
    logic                  burst_empty_i;
    logic                  burst_deq_o;
    logic [15:0]           rd_d_o;
    logic                  rd_enq_o;
    logic                  rd_full_i;
    logic [127:0]          rd_burst_d_o;
    logic                  rd_burst_enq_o;
    logic                  rd_burst_full_i;
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [15:0]           mem_wdata_o;
    logic                  mem_ready_i;
    logic                  mem_rvalid_i;
    logic [15:0]           mem_rdata_i;

    // master is the responder itself; slave is the FIFO/memory side
    modport master (
        input  cmd_q_i, cmd_empty_i, burst_q_i, burst_empty_i, rd_full_i, rd_burst_full_i,
               mem_ready_i, mem_rvalid_i, mem_rdata_i,
        output cmd_deq_o, burst_deq_o, rd_d_o, rd_enq_o, rd_burst_d_o, rd_burst_enq_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport slave (
        output cmd_q_i, cmd_empty_i, burst_q_i, burst_empty_i, rd_full_i, rd_burst_full_i,
               mem_ready_i, mem_rvalid_i, mem_rdata_i,
        input  cmd_deq_o, burst_deq_o, rd_d_o, rd_enq_o, rd_burst_d_o, rd_burst_enq_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/fb_mem_responder.sv
// rtl/fb_mem_responder.sv - executes framebuffer FIFO commands as 16-bit memory accesses
module fb_mem_responder #(
    parameter int ADDR_WIDTH  = 24,
    parameter int BURST_WORDS = 8
) (
    input  logic                clk,
    input  logic                reset_n_i,
    fb_mem_responder_if.master  bus,
    output logic                busy_o,
    output logic                err_o
);
    localparam int IDX_W = $clog2(BURST_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_WORDS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_DISPATCH, S_SWR, S_SRD, S_RD_WAIT, S_RESP,
        S_BRD, S_BRD_WAIT, S_BRESP, S_BWR_FETCH, S_BWR
    } state_t;

    state_t             state_q, state_d;
    logic [40:0]        cmd_reg_q, cmd_reg_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        wbuf_q, wbuf_d;
    logic [15:0]        rd_data_q, rd_data_d;
    logic [127:0]       rd_burst_q, rd_burst_d;

    logic                  cmd_deq, burst_deq, rd_enq, rd_burst_enq;
    logic                  mem_req, mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_wdata;
    logic                  err;

    logic                  cmd_we;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [ADDR_WIDTH-1:0] burst_addr;
    logic [15:0]           burst_word;

    assign cmd_we     = cmd_reg_q[40];
    assign cmd_addr   = cmd_reg_q[16 +: ADDR_WIDTH];
    // Bursts stay inside their 8-aligned block: base has the low bits cleared
    assign burst_addr = {cmd_addr[ADDR_WIDTH-1:IDX_W], {IDX_W{1'b0}}} + ADDR_WIDTH'(idx_q);
    assign burst_word = idx_q[0] ? wbuf_q[31:16] : wbuf_q[15:0];

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= S_IDLE;
            cmd_reg_q  <= '0;
            idx_q      <= '0;
            wbuf_q     <= '0;
            rd_data_q  <= '0;
            rd_burst_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_reg_q  <= cmd_reg_d;
            idx_q      <= idx_d;
            wbuf_q     <= wbuf_d;
            rd_data_q  <= rd_data_d;
            rd_burst_q <= rd_burst_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_reg_d    = cmd_reg_q;
        idx_d        = idx_q;
        wbuf_d       = wbuf_q;
        rd_data_d    = rd_data_q;
        rd_burst_d   = rd_burst_q;
        cmd_deq      = 1'b0;
        burst_deq    = 1'b0;
        rd_enq       = 1'b0;
        rd_burst_enq = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        err          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!bus.cmd_empty_i) begin
                    cmd_deq   = 1'b1;
                    cmd_reg_d = bus.cmd_q_i;
                    state_d   = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                idx_d = '0;
                if (cmd_we) begin
                    state_d = S_SWR;
                end else begin
                    case (cmd_reg_q[1:0])
                        2'b00:   state_d = S_SRD;
                        2'b01:   state_d = S_BRD;
                        2'b10:   state_d = S_BWR_FETCH;
                        default: begin
                            err     = 1'b1;
                            state_d = S_IDLE;
                        end
                    endcase
                end
            end
            S_SWR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cmd_addr;
                mem_wdata = cmd_reg_q[15:0];
                if (bus.mem_ready_i) state_d = S_IDLE;
            end
            S_SRD: begin
                mem_req  = 1'b1;
                mem_addr = cmd_addr;
                if (bus.mem_ready_i) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (bus.mem_rvalid_i) begin
                    rd_data_d = bus.mem_rdata_i;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (!bus.rd_full_i) begin
                    rd_enq  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_BRD: begin
                mem_req  = 1'b1;
                mem_addr = burst_addr;
                if (bus.mem_ready_i) state_d = S_BRD_WAIT;
            end
            S_BRD_WAIT: begin
                if (bus.mem_rvalid_i) begin
                    rd_burst_d[{idx_q, 4'b0000} +: 16] = bus.mem_rdata_i;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_BRESP;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_BRD;
                    end
                end
            end
            S_BRESP: begin
                if (!bus.rd_burst_full_i) begin
                    rd_burst_enq = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_BWR_FETCH: begin
                // Each 32-bit pop feeds two words: only even indices pop
                if (idx_q[0]) begin
                    state_d = S_BWR;
                end else if (!bus.burst_empty_i) begin
                    burst_deq = 1'b1;
                    wbuf_d    = bus.burst_q_i;
                    state_d   = S_BWR;
                end
            end
            S_BWR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = burst_addr;
                mem_wdata = burst_word;
                if (bus.mem_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_BWR_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The pop is the only output decoded from IDLE, so it is masked while reset is held
    assign bus.cmd_deq_o      = cmd_deq & reset_n_i;
    assign bus.burst_deq_o    = burst_deq;
    assign bus.rd_d_o         = rd_data_q;
    assign bus.rd_enq_o       = rd_enq;
    assign bus.rd_burst_d_o   = rd_burst_q;
    assign bus.rd_burst_enq_o = rd_burst_enq;
    assign bus.mem_req_o      = mem_req;
    assign bus.mem_we_o       = mem_we;
    assign bus.mem_addr_o     = mem_addr;
    assign bus.mem_wdata_o    = mem_wdata;
    assign busy_o             = (state_q != S_IDLE);
    assign err_o              = err;
endmodule

// File: tb/tb_fb_mem_responder.sv
// tb/tb_fb_mem_responder.sv - scoreboard bench for fb_mem_responder
module tb_fb_mem_responder;
    localparam int AW = 24;

    logic clk = 1'b0;
    logic reset_n_i;
    logic busy_o, err_o;

    always #5 clk = ~clk;

    fb_mem_responder_if #(.ADDR_WIDTH(AW)) bus ();

    fb_mem_responder #(.ADDR_WIDTH(AW), .BURST_WORDS(8)) dut (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .bus       (bus),
        .busy_o    (busy_o),
        .err_o     (err_o)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [15:0]   wdata;
    } acc_t;

    int n_vec = 0;
    int n_bad = 0;

    acc_t         exp_acc[$];
    logic [15:0]  exp_rd[$];
    logic [127:0] exp_burst[$];
    int           exp_err_q[$];
    logic [40:0]  cmd_fifo[$];
    logic [31:0]  burst_fifo[$];
    logic [15:0]  ref_mem[int];
    logic [15:0]  phys[int];

    int  acc_seen = 0;
    int  burst_gap = 0;
    int  full_force = 0;
    bit  rd_pending = 0;
    int  rd_delay = 0;
    int  rd_addr = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: DUT event with nothing expected", name);
    endtask

    function automatic logic [15:0] dflt(input int a);
        return a[15:0] ^ 16'hC35A ^ {a[23:16], 8'h00};
    endfunction

    function automatic logic [15:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [15:0] phys_rd(input int a);
        return phys.exists(a) ? phys[a] : dflt(a);
    endfunction

    // Reference model: a command becomes the list of memory accesses and FIFO results it must produce
    task automatic issue_cmd(input logic [40:0] c, input logic [127:0] bw);
        int a, base;
        logic [127:0] r;
        logic [31:0] w;
        logic [15:0] h;
        a    = int'(c[39:16]);
        base = a & 32'hFFFF_FFF8;
        r    = '0;
        if (c[40]) begin
            exp_acc.push_back({1'b1, c[39:16], c[15:0]});
            ref_mem[a] = c[15:0];
        end else begin
            case (c[1:0])
                2'b00: begin
                    exp_acc.push_back({1'b0, c[39:16], 16'h0000});
                    exp_rd.push_back(ref_rd(a));
                end
                2'b01: begin
                    for (int i = 0; i < 8; i++) begin
                        exp_acc.push_back({1'b0, AW'(base + i), 16'h0000});
                        r[16*i +: 16] = ref_rd(base + i);
                    end
                    exp_burst.push_back(r);
                end
                2'b10: begin
                    for (int j = 0; j < 4; j++) begin
                        w = bw[32*j +: 32];
                        burst_fifo.push_back(w);
                        for (int k = 0; k < 2; k++) begin
                            h = (k == 0) ? w[15:0] : w[31:16];
                            exp_acc.push_back({1'b1, AW'(base + 2*j + k), h});
                            ref_mem[base + 2*j + k] = h;
                        end
                    end
                end
                default: exp_err_q.push_back(a);
            endcase
        end
        cmd_fifo.push_back(c);
    endtask

    // FIFO/memory environment plus scoreboard monitor
    initial begin : env
        bit   pop_c, pop_b, prev_stall;
        acc_t prev, cur, e;
        prev_stall = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            pop_c = 0;
            pop_b = 0;
            if (bus.cmd_deq_o) begin
                chk("cmd_pop_when_empty", bus.cmd_empty_i, 1'b0);
                pop_c = 1;
            end
            if (bus.burst_deq_o) begin
                chk("burst_pop_when_empty", bus.burst_empty_i, 1'b0);
                pop_b = 1;
            end
            cur = {bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o};
            if (prev_stall)
                chk("req_held_stable", {bus.mem_req_o, cur}, {1'b1, prev});
            if (bus.mem_req_o && bus.mem_ready_i) begin
                prev_stall = 0;
                acc_seen++;
                if (exp_acc.size() == 0) begin
                    miss("mem_access");
                end else begin
                    e = exp_acc.pop_front();
                    chk("acc_we", bus.mem_we_o, e.we);
                    chk("acc_addr", bus.mem_addr_o, e.addr);
                    if (e.we) chk("acc_wdata", bus.mem_wdata_o, e.wdata);
                end
                if (bus.mem_we_o) begin
                    phys[int'(bus.mem_addr_o)] = bus.mem_wdata_o;
                end else begin
                    rd_pending = 1;
                    rd_delay   = $urandom_range(0, 3);
                    rd_addr    = int'(bus.mem_addr_o);
                end
            end else begin
                prev_stall = bus.mem_req_o;
                prev       = cur;
            end
            if (bus.rd_enq_o) begin
                chk("rd_push_when_full", bus.rd_full_i, 1'b0);
                if (exp_rd.size() == 0) miss("rd_push");
                else chk("rd_data", bus.rd_d_o, exp_rd.pop_front());
            end
            if (bus.rd_burst_enq_o) begin
                chk("burst_push_when_full", bus.rd_burst_full_i, 1'b0);
                if (exp_burst.size() == 0) miss("burst_push");
                else chk("burst_data", bus.rd_burst_d_o, exp_burst.pop_front());
            end
            if (err_o) begin
                if (exp_err_q.size() == 0) miss("err_pulse");
                else void'(exp_err_q.pop_front());
            end
            @(posedge clk);
            #1;
            if (pop_c && cmd_fifo.size() != 0) void'(cmd_fifo.pop_front());
            if (pop_b && burst_fifo.size() != 0) void'(burst_fifo.pop_front());
            bus.cmd_empty_i = (cmd_fifo.size() == 0) || ($urandom_range(0, 3) == 0);
            bus.cmd_q_i     = (cmd_fifo.size() != 0) ? cmd_fifo[0] : '0;
            if (burst_gap > 0) begin
                burst_gap--;
                bus.burst_empty_i = 1'b1;
            end else begin
                bus.burst_empty_i = (burst_fifo.size() == 0) || ($urandom_range(0, 2) == 0);
            end
            bus.burst_q_i   = (burst_fifo.size() != 0) ? burst_fifo[0] : '0;
            bus.mem_ready_i = ($urandom_range(0, 2) != 0);
            if (full_force > 0) begin
                full_force--;
                bus.rd_full_i = 1'b1;
            end else begin
                bus.rd_full_i = ($urandom_range(0, 3) == 0);
            end
            bus.rd_burst_full_i = ($urandom_range(0, 3) == 0);
            bus.mem_rdata_i     = 16'($urandom);
            if (rd_pending) begin
                if (rd_delay == 0) begin
                    bus.mem_rvalid_i = 1'b1;
                    bus.mem_rdata_i  = phys_rd(rd_addr);
                    rd_pending       = 0;
                end else begin
                    rd_delay--;
                    bus.mem_rvalid_i = 1'b0;
                end
            end else begin
                bus.mem_rvalid_i = ($urandom_range(0, 7) == 0);
            end
        end
    end

    task automatic drain(input string name);
        bit done;
        done = 0;
        for (int k = 0; k < 8000 && !done; k++) begin
            @(negedge clk);
            done = (cmd_fifo.size() == 0) && !busy_o && (exp_acc.size() == 0) &&
                   (exp_rd.size() == 0) && (exp_burst.size() == 0) && (exp_err_q.size() == 0);
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: drain timeout, %0d accesses %0d reads %0d bursts %0d errs pending",
                     name, exp_acc.size(), exp_rd.size(), exp_burst.size(), exp_err_q.size());
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_err"}, err_o, 1'b0);
        chk({tag, "_req"}, {bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o}, '0);
        chk({tag, "_pushes"}, {bus.rd_enq_o, bus.rd_burst_enq_o, bus.cmd_deq_o, bus.burst_deq_o}, '0);
        chk({tag, "_rd_d"}, bus.rd_d_o, 16'h0000);
        chk({tag, "_rd_burst_d"}, bus.rd_burst_d_o, 128'h0);
    endtask

    initial begin : stim
        logic [31:0] r0, r1;
        logic [40:0] c;
        logic [127:0] bw;
        int s;
        bus.cmd_q_i = '0;         bus.cmd_empty_i = 1'b1;
        bus.burst_q_i = '0;       bus.burst_empty_i = 1'b1;
        bus.rd_full_i = 1'b0;     bus.rd_burst_full_i = 1'b0;
        bus.mem_ready_i = 1'b0;   bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i = '0;
        reset_n_i = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset_n_i = 1'b1;

        ref_mem[32'h123] = 16'h5A5A;
        phys[32'h123]    = 16'h5A5A;
        for (int i = 0; i < 8; i++) begin
            ref_mem[32'h800010 + i] = 16'h1000 + 16'(i);
            phys[32'h800010 + i]    = 16'h1000 + 16'(i);
        end
        issue_cmd({1'b1, 24'h800010, 16'hABCD}, '0);
        full_force = 15;
        issue_cmd({1'b0, 24'h000123, 16'h0000}, '0);
        issue_cmd({1'b0, 24'h800013, 16'h0001}, '0);
        issue_cmd({1'b0, 24'h000045, 16'h0002},
                  {32'h00080007, 32'h00060005, 32'h00040003, 32'h00020001});
        issue_cmd({1'b0, 24'h000055, 16'h0003}, '0);
        issue_cmd({1'b1, 24'h000056, 16'h1234}, '0);
        for (int k = 0; k < 4000 && burst_fifo.size() > 2; k++) @(negedge clk);
        burst_gap = 5;
        drain("directed");

        for (int n = 0; n < 150; n++) begin
            r0 = $urandom;
            r1 = $urandom;
            c  = {r0[0], (r0[1] ? 8'h80 : 8'h00), 10'h000, r0[7:2], r1[15:0]};
            if (!c[40] && c[1:0] == 2'b11 && r0[8]) c[1:0] = 2'b00;
            bw = {$urandom, $urandom, $urandom, $urandom};
            issue_cmd(c, bw);
            if (r0[12:9] == 0) drain("random_batch");
        end
        drain("random");

        s = acc_seen;
        issue_cmd({1'b0, 24'h000203, 16'h0001}, '0);
        for (int k = 0; k < 2000 && acc_seen < s + 3; k++) @(posedge clk);
        chk("reset_point_reached", acc_seen >= s + 3, 1'b1);
        #3;
        reset_n_i = 1'b0;
        exp_acc.delete();
        exp_burst.delete();
        cmd_fifo.delete();
        rd_pending = 0;
        @(negedge clk);
        check_idle_outputs("midreset");
        @(negedge clk);
        reset_n_i = 1'b1;
        issue_cmd({1'b1, 24'h000300, 16'hBEEF}, '0);
        issue_cmd({1'b0, 24'h000300, 16'h0000}, '0);
        drain("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
